// File: rtl/ifu_icb_arbiter_pkg.sv
// Shared constants for the IFU/LSU ICB arbiter: master IDs, default depth, bus widths.
`ifndef PC_Size
`define PC_Size 32
`endif
`ifndef IR_Size
`define IR_Size 32
`endif

package ifu_icb_arbiter_pkg;

   localparam int unsigned ARB_AW             = `PC_Size;
   localparam int unsigned ARB_DW             = `IR_Size;
   localparam int unsigned OUTS_DEPTH_DEFAULT = 2;

   localparam logic ARB_ID_IFU = 1'b0;
   localparam logic ARB_ID_LSU = 1'b1;

   // Pointer width for a FIFO of the given depth; never narrower than one bit.
   function automatic int unsigned ptr_w(int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ifu_icb_arbiter_if.sv
// ICB command/response bundle; master drives commands, slave drives responses.
interface ifu_icb_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [AW-1:0]   cmd_addr;
   logic            cmd_read;
   logic [DW-1:0]   cmd_wdata;
   logic [DW/8-1:0] cmd_wmask;
   logic            rsp_valid;
   logic            rsp_ready;
   logic            rsp_err;
   logic [DW-1:0]   rsp_rdata;

   modport master (
      output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
      output cmd_ready, rsp_valid, rsp_err, rsp_rdata
   );
endinterface

// File: rtl/ifu_arb_id_fifo.sv
// In-order FIFO of 1-bit owner IDs for outstanding arbiter commands.
module ifu_arb_id_fifo
   import ifu_icb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = OUTS_DEPTH_DEFAULT,
   localparam int unsigned PW   = ptr_w(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          din,
   output logic          dout,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   logic [DEPTH-1:0] mem_q;
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         // Push and pop together leave the occupancy unchanged.
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/ifu_icb_arbiter.sv
// Round-robin 2:1 ICB arbiter sharing the ITCM port between IFU fetch (m0) and LSU/debug (m1).
module ifu_icb_arbiter
   import ifu_icb_arbiter_pkg::*;
#(
   parameter int unsigned AW         = ARB_AW,
   parameter int unsigned DW         = ARB_DW,
   parameter int unsigned OUTS_DEPTH = OUTS_DEPTH_DEFAULT,
   localparam int unsigned CW        = $clog2(OUTS_DEPTH) + 1
) (
   input  logic clk,
   input  logic rst,
   ifu_icb_arbiter_if.slave  m0,
   ifu_icb_arbiter_if.slave  m1,
   ifu_icb_arbiter_if.master s,
   output logic arb_idle,
   output logic arb_err
);

   logic          gnt_id;
   logic          last_grant_q;
   logic          cmd_hs, rsp_hs;
   logic          head_id;
   logic          fifo_empty, fifo_full;
   logic [CW-1:0] fifo_count;

   // Tie goes to whichever master was not granted last.
   always_comb begin
      gnt_id = ARB_ID_IFU;
      if (m0.cmd_valid && m1.cmd_valid) begin
         gnt_id = ~last_grant_q;
      end else if (m1.cmd_valid) begin
         gnt_id = ARB_ID_LSU;
      end
   end

   assign s.cmd_valid = ~rst & (m0.cmd_valid | m1.cmd_valid) & ~fifo_full;
   assign s.cmd_addr  = (gnt_id == ARB_ID_LSU) ? m1.cmd_addr  : m0.cmd_addr;
   assign s.cmd_read  = (gnt_id == ARB_ID_LSU) ? m1.cmd_read  : 1'b1;
   assign s.cmd_wdata = (gnt_id == ARB_ID_LSU) ? m1.cmd_wdata : '0;
   assign s.cmd_wmask = (gnt_id == ARB_ID_LSU) ? m1.cmd_wmask : '0;

   assign m0.cmd_ready = ~rst & s.cmd_ready & ~fifo_full & (gnt_id == ARB_ID_IFU);
   assign m1.cmd_ready = ~rst & s.cmd_ready & ~fifo_full & (gnt_id == ARB_ID_LSU);

   assign cmd_hs = s.cmd_valid & s.cmd_ready;

   // Only the valid is steered; data and error fan out to both masters.
   assign m0.rsp_valid = ~rst & s.rsp_valid & ~fifo_empty & (head_id == ARB_ID_IFU);
   assign m1.rsp_valid = ~rst & s.rsp_valid & ~fifo_empty & (head_id == ARB_ID_LSU);
   assign m0.rsp_rdata = s.rsp_rdata;
   assign m1.rsp_rdata = s.rsp_rdata;
   assign m0.rsp_err   = s.rsp_err;
   assign m1.rsp_err   = s.rsp_err;

   assign s.rsp_ready = ~rst & ~fifo_empty &
                        ((head_id == ARB_ID_LSU) ? m1.rsp_ready : m0.rsp_ready);

   assign rsp_hs = s.rsp_valid & s.rsp_ready;

   assign arb_idle = (fifo_count == '0) & ~s.cmd_valid;

   ifu_arb_id_fifo #(
      .DEPTH (OUTS_DEPTH)
   ) u_id_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_hs),
      .pop   (rsp_hs),
      .din   (gnt_id),
      .dout  (head_id),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= ARB_ID_LSU;
         arb_err      <= 1'b0;
      end else begin
         if (cmd_hs) begin
            last_grant_q <= gnt_id;
         end
         // A response with nothing outstanding is a slave protocol violation.
         if (s.rsp_valid && fifo_empty) begin
            arb_err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/ifu_icb_arbiter.md
Name: ifu_icb_arbiter

Overview:
Two-master to one-slave ICB arbiter that shares the instruction-memory (ITCM) ICB port between the IFU fetch path (master 0) and the LSU/debug data path (master 1).
- Round-robin grant on the command channel.
- Records the owner of every outstanding command in an in-order ID FIFO and routes each response back to its owner.
- Provides an idle indication for IFU halt/flush logic.

Parameters:
AW, 32, address width (equals PC_Size)
DW, 32, data width (equals IR_Size)
OUTS_DEPTH, 2, maximum outstanding commands (power of two, 1..8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
m0_cmd_valid  in  1  IFU fetch request
m0_cmd_ready  out  1  IFU request accepted
m0_cmd_addr  in  AW  fetch PC
m0_rsp_valid  out  1  response to IFU
m0_rsp_ready  in  1  IFU accepts response
m0_rsp_err  out  1  bus error
m0_rsp_rdata  out  DW  instruction
m1_cmd_valid  in  1  LSU request
m1_cmd_ready  out  1  LSU request accepted
m1_cmd_addr  in  AW  address
m1_cmd_read  in  1  1=read, 0=write
m1_cmd_wdata  in  DW  write data
m1_cmd_wmask  in  DW/8  byte enables
m1_rsp_valid  out  1  response to LSU
m1_rsp_ready  in  1  LSU accepts response
m1_rsp_err  out  1  bus error
m1_rsp_rdata  out  DW  read data
s_cmd_valid  out  1  slave command valid
s_cmd_ready  in  1  slave accepts command
s_cmd_addr  out  AW  muxed address
s_cmd_read  out  1  m0 always drives 1
s_cmd_wdata  out  DW  m0 drives 0
s_cmd_wmask  out  DW/8  m0 drives 0
s_rsp_valid  in  1  slave response
s_rsp_ready  out  1  arbiter accepts response
s_rsp_err  in  1  error
s_rsp_rdata  in  DW  data
arb_idle  out  1  no outstanding command
arb_err  out  1  sticky protocol error

Behaviour:
- Reset (rst high, async): ID FIFO empty, count=0, last_grant=1 (so m0 wins the first tie), arb_err=0. arb_idle=1 and all valid/ready outputs are 0 while rst is high.
- fifo_full = (count==OUTS_DEPTH). When fifo_full:
  - s_cmd_valid=0, m0_cmd_ready=0, m1_cmd_ready=0.
  - No push/pop bypass: a pop in the same cycle frees the slot only from the next cycle.
- Grant, combinational, zero-latency:
  - Only one master valid: that master is granted.
  - Both valid: grant goes to ~last_grant.
  - s_cmd_valid = (m0_cmd_valid | m1_cmd_valid) & ~fifo_full.
  - Granted master's cmd_ready = s_cmd_ready & ~fifo_full; the other master's cmd_ready=0.
  - The command mux follows the grant.
- Grant stability: grant is recomputed each cycle. Masters hold valid until their handshake; the arbiter does not lock on a stalled slave.
- last_grant updates only on a command handshake (s_cmd_valid & s_cmd_ready).
- On a command handshake: push grant ID (1 bit) into the FIFO; count += 1.
- Response routing uses the FIFO head ID:
  - Head=0: m0_rsp_valid = s_rsp_valid & ~empty. Head=1: m1_rsp_valid likewise.
  - rdata/err pass through to both masters unconditionally. Only the valid is qualified.
  - s_rsp_ready = selected master's rsp_ready & ~empty.
  - On a response handshake: pop, count -= 1.
- Simultaneous command and response handshakes: count unchanged, FIFO pointers both advance.
- Pointer wrap: read/write pointers are log2(OUTS_DEPTH) bits with natural wrap. count is a separate log2(OUTS_DEPTH)+1-bit counter.
- arb_idle = (count==0) & ~s_cmd_valid.
- Response with empty FIFO: s_rsp_ready=0, no master valid, arb_err set. arb_err is sticky until rst.
- Latency: command 0 cycles through the mux; response 0 cycles through the mux. No internal registers on data paths.

Decomposition:
- Shared package constants: ARB_ID_IFU=1'b0, ARB_ID_LSU=1'b1, and the default OUTS_DEPTH. AW/DW come from the global PC_Size/IR_Size defines.
- One sub-module, ifu_arb_id_fifo:
  - Parameterised depth, 1-bit payload.
  - Ports: push, pop, din, dout, empty, full, count.
  - Asynchronous active-high reset.

Test Plan:
- After rst, m0_cmd_valid=1, addr=0x8000_0000, s_cmd_ready=1 -> s_cmd_addr=0x8000_0000, s_cmd_read=1, m0_cmd_ready=1 same cycle, arb_idle=0 next cycle. Slave returns rdata=0x0000_0013 -> m0_rsp_valid=1, m1_rsp_valid=0, arb_idle=1 after pop.
- Both masters valid for 4 cycles, s_cmd_ready=1, responses returned each cycle -> grants m0,m1,m0,m1. Responses route in the same order.
- OUTS_DEPTH=2, two m0 commands accepted, no response -> third cycle both cmd_ready=0, s_cmd_valid=0. One response pop -> command accepted the following cycle, not the same cycle.
- m1 write (read=0, wdata=0xDEAD_BEEF, wmask=4'b1100) while m0 holds rsp_ready=0 with its response pending at the head -> s_rsp_ready=0. m1's later response is held until m0 takes its response (in-order).
- s_rsp_valid=1 with the FIFO empty -> s_rsp_ready=0, no master rsp_valid, arb_err=1 and stays 1 until rst.
- Assert rst mid-transaction with count=1 -> count=0, arb_idle=1, all valids 0 immediately (asynchronous). The first grant after release goes to m0 on a tie.
